mult_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide engine: the responder side of the EX-stage mult/div handshake. EX presents funct and operands every cycle and stalls the pipeline while done is low. The unit computes MULT/MULTU/DIV/DIVU results and presents a 64-bit {hi, lo} result with done for EX to write into HILO. It sits beside EX and is clocked with the pipeline.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit_div_step.sv | 18 +
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: funct codes, FSM state encoding and decode helpers for the mult/div engine
package mult_div_unit_pkg;
   localparam int FUNCT_BUS = 6;
   localparam int MULT_DIV_BUS = 64;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1a;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1b;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

   function automatic logic is_md(input logic [FUNCT_BUS-1:0] f);
      return f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU;
   endfunction

   function automatic logic is_signed_op(input logic [FUNCT_BUS-1:0] f);
      return f == FUNCT_MULT || f == FUNCT_DIV;
   endfunction

   function automatic logic is_div_op(input logic [FUNCT_BUS-1:0] f);
      return f == FUNCT_DIV || f == FUNCT_DIVU;
   endfunction
endpackage

// File: rtl/mult_div_unit_div_step.sv
// mult_div_unit_div_step: one restoring-division iteration on unsigned magnitudes
module mult_div_unit_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] div_i,
   input  logic         bit_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);
   logic [W:0] trial;
   logic [W:0] diff;
   assign trial = {rem_i, bit_i};
   assign diff  = trial - {1'b0, div_i};
   assign q_o   = trial >= {1'b0, div_i};
   // When the subtract succeeds the difference is below the divisor, so it fits in W bits
   assign rem_o = q_o ? diff[W-1:0] : trial[W-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide responder for the EX-stage HILO handshake
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FUNCT_BUS-1:0]      funct,
   input  logic [DATA_WIDTH-1:0]     operand_1,
   input  logic [DATA_WIDTH-1:0]     operand_2,
   input  logic                      stall,
   input  logic                      flush,
   output logic                      mult_div_done,
   output logic [2*DATA_WIDTH-1:0]   mult_div_result
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   md_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_div_q, is_div_d;
   logic          neg_q, neg_d;
   logic          rneg_q, rneg_d;
   logic          dz_q, dz_d;
   logic [W-1:0]  op1_q, op1_d;
   logic [W-1:0]  b_q, b_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] res_q, res_d;

   logic          sgn, s1, s2, div_op;
   logic [W-1:0]  abs1, abs2;
   logic [W:0]    mul_sum;
   logic [2*W-1:0] mul_nxt, div_nxt, step, fix_mul, fix_div;
   logic [W-1:0]  drem;
   logic          qbit;

   assign sgn    = is_signed_op(funct);
   assign div_op = is_div_op(funct);
   assign s1     = sgn & operand_1[W-1];
   assign s2     = sgn & operand_2[W-1];
   assign abs1   = s1 ? -operand_1 : operand_1;
   assign abs2   = s2 ? -operand_2 : operand_2;

   // acc holds {hi, lo}: multiply shifts the product in from the top while the multiplier drains from lo;
   // divide shifts the dividend out of lo into the partial remainder in hi and quotient bits into lo
   assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_nxt = {mul_sum, acc_q[W-1:1]};
   assign div_nxt = {drem, acc_q[W-2:0], qbit};
   assign step    = is_div_q ? div_nxt : mul_nxt;

   mult_div_unit_div_step #(.W(W)) u_div_step (
      .rem_i (acc_q[2*W-1:W]),
      .div_i (b_q),
      .bit_i (acc_q[W-1]),
      .rem_o (drem),
      .q_o   (qbit)
   );

   assign fix_mul = neg_q ? -step : step;
   assign fix_div = dz_q ? {op1_q, {W{1'b1}}}
                         : {rneg_q ? -step[2*W-1:W] : step[2*W-1:W], neg_q ? -step[W-1:0] : step[W-1:0]};

   assign mult_div_done   = state_q == MD_DONE;
   assign mult_div_result = res_q;

   // Next-state: latch operands on start, iterate while busy, hold done under stall; flush overrides all
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      op1_d    = op1_q;
      b_d      = b_q;
      acc_d    = acc_q;
      res_d    = res_q;
      if (flush) begin
         state_d = MD_IDLE;
      end else begin
         unique case (state_q)
            MD_IDLE: if (is_md(funct)) begin
               state_d  = MD_BUSY;
               cnt_d    = '0;
               is_div_d = div_op;
               neg_d    = s1 ^ s2;
               rneg_d   = s1;
               dz_d     = div_op && operand_2 == '0;
               op1_d    = operand_1;
               b_d      = div_op ? abs2 : abs1;
               acc_d    = {{W{1'b0}}, div_op ? abs1 : abs2};
            end
            MD_BUSY: begin
               acc_d = step;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(W-1)) begin
                  res_d   = is_div_q ? fix_div : fix_mul;
                  state_d = MD_DONE;
               end
            end
            MD_DONE: state_d = stall ? MD_DONE : MD_IDLE;
            default: state_d = MD_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         op1_q    <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         op1_q    <= op1_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         res_q    <= res_d;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with an arithmetic reference model
module tb_mult_div_unit;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b, F_NOP = 6'h20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  funct = F_NOP;
   logic [31:0] operand_1 = '0;
   logic [31:0] operand_2 = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        mult_div_done;
   logic [63:0] mult_div_result;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        done_prev = 1'b0;
   logic [63:0] last_res = '0;

   mult_div_unit dut (
      .clk             (clk),
      .rst             (rst),
      .funct           (funct),
      .operand_1       (operand_1),
      .operand_2       (operand_2),
      .stall           (stall),
      .flush           (flush),
      .mult_div_done   (mult_div_done),
      .mult_div_result (mult_div_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if ((f == F_DIV || f == F_DIVU) && b == 0) return {a, 32'hffff_ffff};
      case (f)
         F_MULT:  return 64'(sa * sb);
         F_MULTU: return {32'b0, a} * {32'b0, b};
         F_DIV: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rising edge of done pops one expected result and its expected completion cycle
   always @(negedge clk) begin
      exp_t e;
      if (mult_div_done && !done_prev) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'(mult_div_done), 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("result", mult_div_result, e.res);
            chk("latency", 64'(cyc), 64'(e.cyc));
         end
      end
      done_prev <= mult_div_done;
   end

   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int stall_n);
      exp_t        e;
      int          n;
      logic [63:0] r;
      r = model(f, a, b);
      funct = f;
      operand_1 = a;
      operand_2 = b;
      stall = stall_n > 0;
      e.res = r;
      e.cyc = cyc + 33;
      sb_q.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mult_div_done && n < 40);
      if (!mult_div_done) begin
         chk("done_timeout", 64'(mult_div_done), 64'd1);
         sb_q.delete();
      end
      for (int i = 1; i <= stall_n; i++) begin
         @(posedge clk);
         #1;
         if (i == stall_n) stall = 1'b0;
         @(negedge clk);
         chk("stall_done", 64'(mult_div_done), 64'd1);
         chk("stall_res", mult_div_result, r);
      end
      @(posedge clk);
      #1;
      funct = F_NOP;
      stall = 1'b0;
      chk("done_drop", 64'(mult_div_done), 64'd0);
      last_res = r;
   endtask

   task automatic expect_quiet(input string name);
      logic seen;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (mult_div_done) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pool [6];
      logic [31:0] a, b;
      logic [5:0]  f;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_done", 64'(mult_div_done), 64'd0);
      chk("reset_res", mult_div_result, 64'd0);

      do_op(F_MULTU, 32'hffff_ffff, 32'hffff_ffff, 0);
      chk("multu_max", last_res, 64'hffff_fffe_0000_0001);
      do_op(F_MULT, 32'hffff_fffd, 32'd5, 0);
      do_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      do_op(F_DIV, 32'hffff_fff9, 32'd2, 0);
      do_op(F_DIVU, 32'd7, 32'd2, 0);
      do_op(F_DIV, 32'h8000_0000, 32'hffff_ffff, 0);
      do_op(F_DIVU, 32'h1234, 32'd0, 0);
      do_op(F_DIV, 32'h1234, 32'd0, 0);
      do_op(F_DIV, 32'hffff_ff00, 32'd0, 0);

      // Flush mid-multiply: no done, result untouched, next op runs normally
      funct = F_MULTU;
      operand_1 = 32'hdead_beef;
      operand_2 = 32'h1234_5678;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      funct = F_NOP;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_done", 64'(mult_div_done), 64'd0);
      expect_quiet("flush_no_done");
      chk("flush_res", mult_div_result, last_res);
      do_op(F_MULTU, 32'd2, 32'd3, 0);
      chk("after_flush", last_res, 64'd6);

      // Flush in IDLE blocks the start
      funct = F_DIVU;
      operand_1 = 32'd9;
      operand_2 = 32'd3;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      funct = F_NOP;
      expect_quiet("idle_flush_no_done");

      // Reset mid-operation clears everything
      funct = F_DIV;
      operand_1 = 32'd1000;
      operand_2 = 32'd7;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      funct = F_NOP;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_done", 64'(mult_div_done), 64'd0);
      chk("rst_mid_res", mult_div_result, 64'd0);
      expect_quiet("rst_no_done");
      last_res = '0;

      // Stall in DONE for 3 cycles, then back-to-back divide
      do_op(F_MULT, 32'h7fff_ffff, 32'hffff_fffe, 3);
      do_op(F_DIVU, 32'd100, 32'd7, 0);
      chk("divu_100_7", last_res, {32'd2, 32'd14});

      pool = '{32'd0, 32'd1, 32'hffff_ffff, 32'h8000_0000, 32'h7fff_ffff, 32'd3};
      for (int i = 0; i < 24; i++) begin
         f = 6'h18 + 6'($urandom_range(0, 3));
         a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         do_op(f, a, b, (i % 5 == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
